// File: rtl/sw_cond_pkg.sv
// Shared constants and width helper for the switch input conditioner.
package sw_cond_pkg;
  localparam int SW_WIDTH         = 32;
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_TICK_DIV     = 50000;
  localparam int DEF_STABLE_TICKS = 10;

  // Bits needed to hold any value in 0..max_val (at least one).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: synchronizer chain plus tick-qualified debouncer.
// Optional registered edge pulses when SW_EDGE_EN is defined.
module sw_debounce_bit
  import sw_cond_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_deb
`ifdef SW_EDGE_EN
  ,
  output logic o_rise,
  output logic o_fall
`endif
);
  localparam int CNT_W = cnt_width(STABLE_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   deb_q;
  logic                   sync;
  logic                   diff;
  logic                   qualify;

  assign sync    = sync_q[SYNC_STAGES-1];
  assign diff    = sync != deb_q;
  assign qualify = diff && i_tick && (cnt_q == CNT_LAST);
  assign o_deb   = deb_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], i_raw};
  end

  // Any cycle back at the debounced level restarts qualification.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else if (!diff) begin
      cnt_q <= '0;
    end else if (i_tick) begin
      if (qualify) begin
        deb_q <= sync;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef SW_EDGE_EN
  // Registered alongside deb_q so the pulse lines up with the output change.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      o_rise <= qualify & sync;
      o_fall <= qualify & ~sync;
    end
  end
`endif
endmodule

// File: rtl/sw_input_conditioner.sv
// Synchronizes and debounces the 32-bit board switch bus for the LSU.
// Define SW_EDGE_EN to add per-bit rise/fall pulse outputs.
module sw_input_conditioner
  import sw_cond_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [SW_WIDTH-1:0] i_io_sw,
  output logic [SW_WIDTH-1:0] o_sw_out
`ifdef SW_EDGE_EN
  ,
  output logic [SW_WIDTH-1:0] o_sw_rise,
  output logic [SW_WIDTH-1:0] o_sw_fall
`endif
);
  localparam int DIV_W = cnt_width(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic             tick;

  // Shared prescaler; every bit qualifies against the same tick.
  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset)   div_q <= '0;
    else if (tick) div_q <= '0;
    else           div_q <= div_q + 1'b1;
  end

  for (genvar b = 0; b < SW_WIDTH; b++) begin : g_bit
    sw_debounce_bit #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_TICKS (STABLE_TICKS)
    ) u_bit (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_tick  (tick),
      .i_raw   (i_io_sw[b]),
      .o_deb   (o_sw_out[b])
`ifdef SW_EDGE_EN
      ,
      .o_rise  (o_sw_rise[b]),
      .o_fall  (o_sw_fall[b])
`endif
    );
  end
endmodule

// File: tb/tb_sw_input_conditioner.sv
// Randomized + directed bench for sw_input_conditioner against a
// tick-counting reference model (SYNC_STAGES=2, TICK_DIV=4, STABLE_TICKS=3).
module tb_sw_input_conditioner;
  localparam int SS = 2;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int W  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  sw_in;
  logic [W-1:0]  sw_out;
`ifdef SW_EDGE_EN
  logic [W-1:0]  sw_rise;
  logic [W-1:0]  sw_fall;
`endif

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  sw_input_conditioner #(
    .SYNC_STAGES  (SS),
    .TICK_DIV     (TD),
    .STABLE_TICKS (ST)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_io_sw   (sw_in),
    .o_sw_out  (sw_out)
`ifdef SW_EDGE_EN
    ,
    .o_sw_rise (sw_rise),
    .o_sw_fall (sw_fall)
`endif
  );

  // Reference model: cycle index since reset release, input history,
  // and for each bit the cycle its synchronized level first diverged.
  int           m_cyc;
  logic [W-1:0] m_hist[$];
  int           m_since[W];
  logic [W-1:0] m_out, m_rise, m_fall;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Tick cycles are those with c % TD == TD-1; count them in [a, c].
  function automatic int ticks_in(input int a, input int c);
    return (c + 1) / TD - a / TD;
  endfunction

  task automatic mdl_step(input logic [W-1:0] v, input logic r);
    logic [W-1:0] nout, nrise, nfall;
    logic         sy;
    if (r) begin
      m_out = '0; m_rise = '0; m_fall = '0;
      m_cyc = 0;
      m_hist.delete();
      for (int b = 0; b < W; b++) m_since[b] = -1;
      return;
    end
    m_hist.push_back(v);
    nout = m_out; nrise = '0; nfall = '0;
    for (int b = 0; b < W; b++) begin
      sy = (m_cyc >= SS) ? m_hist[m_cyc - SS][b] : 1'b0;
      if (sy == m_out[b]) begin
        m_since[b] = -1;
      end else begin
        if (m_since[b] < 0) m_since[b] = m_cyc;
        if (ticks_in(m_since[b], m_cyc) == ST) begin
          nout[b]    = sy;
          nrise[b]   = sy;
          nfall[b]   = ~sy;
          m_since[b] = -1;
        end
      end
    end
    m_out = nout; m_rise = nrise; m_fall = nfall;
    m_cyc++;
  endtask

  task automatic drive(input logic [W-1:0] v, input logic r);
    sw_in = v;
    rst   = r;
    mdl_step(v, r);
    @(posedge clk);
    #1;
    chk("sw_out", sw_out, m_out);
`ifdef SW_EDGE_EN
    chk("sw_rise", sw_rise, m_rise);
    chk("sw_fall", sw_fall, m_fall);
`endif
  endtask

  task automatic run(input logic [W-1:0] v, input int n);
    for (int i = 0; i < n; i++) drive(v, 1'b0);
  endtask

  task automatic hold_rst(input logic [W-1:0] v, input int n);
    for (int i = 0; i < n; i++) drive(v, 1'b1);
  endtask

  initial begin
    logic [W-1:0] v;
    logic [W-1:0] mask;
    logic         r;

    // Reset with all switches high, then let them qualify.
    hold_rst('1, 5);
    run('1, 20);

    // Clean change on bit 3 from an all-zero baseline.
    hold_rst('0, 2);
    run('0, 20);
    v = 32'h0000_0008;
    run(v, 20);

    // Bounce on bit 5: 1,0,1 with 2-cycle spacing then hold.
    v[5] = 1'b1; run(v, 2);
    v[5] = 1'b0; run(v, 2);
    v[5] = 1'b1; run(v, 20);

    // Single-cycle glitch on bit 0.
    v[0] = 1'b1; run(v, 1);
    v[0] = 1'b0; run(v, 20);

    // Reset mid-qualification on bit 7.
    v[7] = 1'b1; run(v, 6);
    hold_rst(v, 1);
    run(v, 20);

    // Qualified 1->0->1 on bit 17.
    v[17] = 1'b1; run(v, 20);
    v[17] = 1'b0; run(v, 20);
    v[17] = 1'b1; run(v, 20);

    // Randomized: alternating bursty and quiet phases, rare resets.
    for (int i = 0; i < 3000; i++) begin
      if ((i % 200) < 100) mask = $urandom & $urandom & $urandom;
      else mask = ($urandom_range(0, 15) == 0) ? ($urandom & $urandom) : '0;
      r = ($urandom_range(0, 599) == 0);
      v = v ^ mask;
      drive(v, r);
    end
    run(v, 20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
